alarm_bank: RTL and testbench

ALARM_BANK -- requirements
Module: alarm_bank

---
 rtl/alarm_pkg.sv | 35 +++
 rtl/alarm_channel.sv | 108 ++++++++++
 rtl/alarm_bank.sv | 69 ++++++
 tb/tb_alarm_bank.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared types and time helpers for the alarm bank.
// Latency: none (types, constants and combinational helpers only).
// Backpressure: none.
package alarm_pkg;

    localparam int TIME_W = 7;
    localparam logic [TIME_W-1:0] MIN_MAX  = 7'd59;
    localparam logic [TIME_W-1:0] HOUR_MAX = 7'd23;

    typedef enum logic [1:0] {
        CH_IDLE,
        CH_RINGING,
        CH_SNOOZED
    } ch_state_t;

    typedef struct packed {
        logic [TIME_W-1:0] hour;
        logic [TIME_W-1:0] min;
    } hm_t;

    // inc is at most 59, so one minute wrap and one hour carry are enough.
    function automatic hm_t add_minutes(hm_t t, logic [TIME_W-1:0] inc);
        hm_t               r;
        logic [TIME_W-1:0] m;
        m      = t.min + inc;
        r.hour = t.hour;
        r.min  = m;
        if (m > MIN_MAX) begin
            r.min  = m - (MIN_MAX + 7'd1);
            r.hour = (t.hour == HOUR_MAX) ? '0 : t.hour + 7'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/alarm_channel.sv
// One alarm channel: config storage, idle/ringing/snoozed FSM, ring counter, snooze target.
// Latency: ring/snoozed reflect a trigger, snooze, dismiss or write one cycle later.
// Backpressure: none; every strobe is consumed in the cycle it is presented.
module alarm_channel
    import alarm_pkg::*;
#(
    parameter int RING_SECS  = 60,
    parameter int SNOOZE_MIN = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sec_tick,
    input  logic [TIME_W-1:0] cur_sec,
    input  hm_t               cur_time,
    input  logic              wr_vld,
    input  hm_t               wr_time,
    input  logic              wr_enable,
    input  logic              snooze,
    input  logic              dismiss,
    output logic              ring,
    output logic              snoozed
);

    localparam logic [7:0]        RING_LOAD = 8'(RING_SECS);
    localparam logic [TIME_W-1:0] SNZ_INC   = TIME_W'(SNOOZE_MIN);

    ch_state_t  st, st_nxt;
    hm_t        set_t, set_nxt;
    hm_t        snz_t, snz_nxt;
    logic       en, en_nxt;
    logic [7:0] ring_cnt, cnt_nxt;

    logic minute_edge, hit_set, hit_snz;

    assign minute_edge = sec_tick && (cur_sec == '0);
    assign hit_set     = minute_edge && (cur_time == set_t);
    assign hit_snz     = minute_edge && (cur_time == snz_t);

    always_ff @(posedge clk) begin
        if (rst) begin
            st       <= CH_IDLE;
            set_t    <= '0;
            snz_t    <= '0;
            en       <= 1'b0;
            ring_cnt <= '0;
        end else begin
            st       <= st_nxt;
            set_t    <= set_nxt;
            snz_t    <= snz_nxt;
            en       <= en_nxt;
            ring_cnt <= cnt_nxt;
        end
    end

    // Priority: write > dismiss > snooze > second tick / minute trigger.
    always_comb begin
        st_nxt  = st;
        set_nxt = set_t;
        snz_nxt = snz_t;
        en_nxt  = en;
        cnt_nxt = ring_cnt;
        if (wr_vld) begin
            set_nxt = wr_time;
            en_nxt  = wr_enable;
            st_nxt  = CH_IDLE;
            cnt_nxt = '0;
        end else begin
            unique case (st)
                CH_IDLE: begin
                    if (en && hit_set) begin
                        st_nxt  = CH_RINGING;
                        cnt_nxt = RING_LOAD;
                    end
                end
                CH_RINGING: begin
                    if (dismiss) begin
                        st_nxt  = CH_IDLE;
                        cnt_nxt = '0;
                    end else if (snooze) begin
                        st_nxt  = CH_SNOOZED;
                        snz_nxt = add_minutes(cur_time, SNZ_INC);
                        cnt_nxt = '0;
                    end else if (sec_tick) begin
                        if (ring_cnt <= 8'd1) begin
                            st_nxt  = CH_IDLE;
                            cnt_nxt = '0;
                        end else begin
                            cnt_nxt = ring_cnt - 8'd1;
                        end
                    end
                end
                CH_SNOOZED: begin
                    if (dismiss) begin
                        st_nxt = CH_IDLE;
                    end else if (hit_snz) begin
                        st_nxt  = CH_RINGING;
                        cnt_nxt = RING_LOAD;
                    end
                end
                default: st_nxt = CH_IDLE;
            endcase
        end
    end

    assign ring    = (st == CH_RINGING);
    assign snoozed = (st == CH_SNOOZED);

endmodule

// File: rtl/alarm_bank.sv
// Bank of N_CH independent alarm channels with write decode and lowest-index ring encoder.
// Latency: ring_vec/snooze_vec one cycle after the causing input; alarm/ring_id add none.
// Backpressure: none; writes with an out-of-range channel or time are dropped.
module alarm_bank
    import alarm_pkg::*;
#(
    parameter  int N_CH       = 4,
    parameter  int RING_SECS  = 60,
    parameter  int SNOOZE_MIN = 5,
    localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sec_tick,
    input  logic [TIME_W-1:0] cur_sec,
    input  logic [TIME_W-1:0] cur_min,
    input  logic [TIME_W-1:0] cur_hour,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_sel,
    input  logic [TIME_W-1:0] wr_hour,
    input  logic [TIME_W-1:0] wr_min,
    input  logic              wr_enable,
    input  logic              snooze,
    input  logic              dismiss,
    output logic [N_CH-1:0]   ring_vec,
    output logic [N_CH-1:0]   snooze_vec,
    output logic              alarm,
    output logic [CH_W-1:0]   ring_id
);

    hm_t  cur_time, wr_time;
    logic wr_ok;

    assign cur_time = {cur_hour, cur_min};
    assign wr_time  = {wr_hour, wr_min};
    assign wr_ok    = wr_en && (32'(wr_sel) < 32'(N_CH))
                      && (wr_hour <= HOUR_MAX) && (wr_min <= MIN_MAX);

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        alarm_channel #(
            .RING_SECS  (RING_SECS),
            .SNOOZE_MIN (SNOOZE_MIN)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .sec_tick  (sec_tick),
            .cur_sec   (cur_sec),
            .cur_time  (cur_time),
            .wr_vld    (wr_ok && (wr_sel == CH_W'(g))),
            .wr_time   (wr_time),
            .wr_enable (wr_enable),
            .snooze    (snooze),
            .dismiss   (dismiss),
            .ring      (ring_vec[g]),
            .snoozed   (snooze_vec[g])
        );
    end

    assign alarm = |ring_vec;

    // Scan from the top so the lowest ringing index wins.
    always_comb begin
        ring_id = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (ring_vec[i]) ring_id = CH_W'(i);
        end
    end

endmodule

// File: tb/tb_alarm_bank.sv
// Scoreboarded bench for alarm_bank: a minute-of-day reference model predicts every cycle.
module tb_alarm_bank;

    localparam int N  = 4;
    localparam int RS = 60;
    localparam int SM = 5;

    logic       clk = 1'b0;
    logic       rst, sec_tick, wr_en, wr_enable, snooze, dismiss;
    logic [6:0] cur_sec, cur_min, cur_hour, wr_hour, wr_min;
    logic [1:0] wr_sel, ring_id;
    logic [3:0] ring_vec, snooze_vec;
    logic       alarm;

    always #5 clk = ~clk;

    alarm_bank #(.N_CH(N), .RING_SECS(RS), .SNOOZE_MIN(SM)) dut (
        .clk        (clk),
        .rst        (rst),
        .sec_tick   (sec_tick),
        .cur_sec    (cur_sec),
        .cur_min    (cur_min),
        .cur_hour   (cur_hour),
        .wr_en      (wr_en),
        .wr_sel     (wr_sel),
        .wr_hour    (wr_hour),
        .wr_min     (wr_min),
        .wr_enable  (wr_enable),
        .snooze     (snooze),
        .dismiss    (dismiss),
        .ring_vec   (ring_vec),
        .snooze_vec (snooze_vec),
        .alarm      (alarm),
        .ring_id    (ring_id)
    );

    typedef struct {
        logic [3:0] ring;
        logic [3:0] snz;
        logic       alm;
        logic [1:0] id;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    // Reference state: 0 idle, 1 ringing, 2 snoozed; times held as minute-of-day.
    int m_st[N], m_set[N], m_en[N], m_tgt[N], m_rem[N];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int   now;
        bit   at_min, wok;
        exp_t e;
        now    = int'(cur_hour) * 60 + int'(cur_min);
        at_min = sec_tick && (cur_sec == 0);
        wok    = wr_en && (wr_hour <= 23) && (wr_min <= 59) && (int'(wr_sel) < N);
        for (int c = 0; c < N; c++) begin
            if (rst) begin
                m_st[c] = 0; m_set[c] = 0; m_en[c] = 0; m_tgt[c] = 0; m_rem[c] = 0;
            end else if (wok && int'(wr_sel) == c) begin
                m_set[c] = int'(wr_hour) * 60 + int'(wr_min);
                m_en[c]  = int'(wr_enable);
                m_st[c]  = 0;
            end else if (m_st[c] == 0) begin
                if (m_en[c] != 0 && at_min && now == m_set[c]) begin
                    m_st[c] = 1; m_rem[c] = RS;
                end
            end else if (m_st[c] == 1) begin
                if (dismiss) m_st[c] = 0;
                else if (snooze) begin
                    m_st[c]  = 2;
                    m_tgt[c] = (now + SM) % 1440;
                end else if (sec_tick) begin
                    m_rem[c]--;
                    if (m_rem[c] == 0) m_st[c] = 0;
                end
            end else begin
                if (dismiss) m_st[c] = 0;
                else if (at_min && now == m_tgt[c]) begin
                    m_st[c] = 1; m_rem[c] = RS;
                end
            end
        end
        e.ring = '0; e.snz = '0; e.id = '0;
        for (int c = 0; c < N; c++) begin
            e.ring[c] = (m_st[c] == 1);
            e.snz[c]  = (m_st[c] == 2);
        end
        e.alm = (e.ring != 0);
        for (int c = N - 1; c >= 0; c--) if (e.ring[c]) e.id = 2'(c);
        sbq.push_back(e);
    endtask

    // Inputs are applied just after a negedge; the model predicts the post-posedge outputs.
    task automatic step();
        model_step();
        @(negedge clk);
        sec_tick = 1'b0; wr_en = 1'b0; snooze = 1'b0; dismiss = 1'b0;
    endtask

    task automatic write_ch(input int sel, input int h, input int m, input bit en);
        wr_en = 1'b1; wr_sel = 2'(sel); wr_hour = 7'(h); wr_min = 7'(m); wr_enable = en;
        step();
    endtask

    task automatic tick_at(input int h, input int m, input int s);
        cur_hour = 7'(h); cur_min = 7'(m); cur_sec = 7'(s); sec_tick = 1'b1;
        step();
    endtask

    task automatic pulse(input bit sn, input bit dis);
        snooze = sn; dismiss = dis;
        step();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("sb_ring_vec",   int'(ring_vec),   int'(e.ring));
                chk("sb_snooze_vec", int'(snooze_vec), int'(e.snz));
                chk("sb_alarm",      int'(alarm),      int'(e.alm));
                chk("sb_ring_id",    int'(ring_id),    int'(e.id));
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        int tod;
        bit tk;
        rst = 1'b1; sec_tick = 1'b0; wr_en = 1'b0; wr_enable = 1'b0;
        snooze = 1'b0; dismiss = 1'b0; wr_sel = '0; wr_hour = '0; wr_min = '0;
        cur_sec = '0; cur_min = '0; cur_hour = '0;
        @(negedge clk);
        step();
        step();
        rst = 1'b0;
        chk("rst_ring_vec", int'(ring_vec), 0);
        chk("rst_snooze_vec", int'(snooze_vec), 0);
        chk("rst_alarm", int'(alarm), 0);
        chk("rst_ring_id", int'(ring_id), 0);

        // Channel 2 at 07:30
        write_ch(2, 7, 30, 1);
        tick_at(7, 30, 0);
        chk("ch2_ring_vec", int'(ring_vec), 4'b0100);
        chk("ch2_alarm", int'(alarm), 1);
        chk("ch2_ring_id", int'(ring_id), 2);
        pulse(0, 1);
        chk("ch2_dismissed", int'(ring_vec), 0);

        // Ring timeout after RS ticks
        write_ch(0, 6, 0, 1);
        tick_at(6, 0, 0);
        for (int i = 1; i < RS; i++) tick_at(6, 0, i);
        chk("timeout_still_ringing", int'(alarm), 1);
        tick_at(6, 1, 0);
        chk("timeout_alarm", int'(alarm), 0);
        chk("timeout_ring_vec", int'(ring_vec), 0);

        // Snooze across midnight
        write_ch(1, 23, 58, 1);
        tick_at(23, 58, 0);
        chk("snz_pre_ring", int'(ring_vec), 4'b0010);
        pulse(1, 0);
        chk("snz_vec", int'(snooze_vec), 4'b0010);
        chk("snz_ring_clear", int'(ring_vec), 0);
        tick_at(0, 2, 0);
        chk("snz_early", int'(ring_vec), 0);
        tick_at(0, 3, 0);
        chk("snz_rering", int'(ring_vec), 4'b0010);
        pulse(0, 1);

        // Two channels, snooze+dismiss together; ring_id with only ch3
        write_ch(0, 8, 0, 1);
        write_ch(3, 8, 0, 1);
        tick_at(8, 0, 0);
        chk("dual_ring_vec", int'(ring_vec), 4'b1001);
        chk("dual_ring_id", int'(ring_id), 0);
        pulse(1, 1);
        chk("dual_after_ring", int'(ring_vec), 0);
        chk("dual_after_snz", int'(snooze_vec), 0);
        chk("dual_after_id", int'(ring_id), 0);
        tick_at(8, 0, 0);
        write_ch(0, 8, 0, 0);
        chk("ch3_only_ring", int'(ring_vec), 4'b1000);
        chk("ch3_only_id", int'(ring_id), 3);
        pulse(0, 1);

        // Invalid writes dropped; disabling write stops ringing
        write_ch(1, 10, 0, 1);
        write_ch(1, 10, 60, 1);
        write_ch(1, 24, 0, 0);
        tick_at(10, 0, 0);
        chk("badwr_ring", int'(ring_vec), 4'b0010);
        write_ch(1, 10, 0, 0);
        chk("wr_force_idle", int'(ring_vec), 0);
        tick_at(10, 0, 0);
        chk("disabled_no_ring", int'(ring_vec), 0);

        // Reset while snoozed
        write_ch(2, 11, 0, 1);
        tick_at(11, 0, 0);
        pulse(1, 0);
        chk("pre_rst_snz", int'(snooze_vec), 4'b0100);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_ring", int'(ring_vec), 0);
        chk("mid_rst_snz", int'(snooze_vec), 0);
        chk("mid_rst_alarm", int'(alarm), 0);
        tick_at(11, 5, 0);
        chk("old_target_ring", int'(ring_vec), 0);
        tick_at(0, 0, 0);
        chk("reset_cfg_ring", int'(ring_vec), 0);

        // Randomized run across midnight
        tod = 23 * 3600 + 55 * 60;
        for (int n = 0; n < 3000; n++) begin
            int r, am;
            cur_hour = 7'(tod / 3600);
            cur_min  = 7'((tod / 60) % 60);
            cur_sec  = 7'(tod % 60);
            tk       = ($urandom_range(0, 1) == 1);
            sec_tick = tk;
            r        = int'($urandom_range(0, 99));
            if (r < 5) begin
                am        = (tod / 60 + int'($urandom_range(0, 4))) % 1440;
                wr_en     = 1'b1;
                wr_sel    = 2'($urandom_range(0, 3));
                wr_hour   = 7'(am / 60);
                wr_min    = 7'(am % 60);
                wr_enable = ($urandom_range(0, 5) != 0);
                if ($urandom_range(0, 7) == 0) wr_min = 7'($urandom_range(60, 127));
                if ($urandom_range(0, 7) == 0) wr_hour = 7'($urandom_range(24, 127));
            end
            snooze  = (r >= 10 && r < 14);
            dismiss = (r == 20) || (r == 21 && $urandom_range(0, 1) == 1);
            rst     = ($urandom_range(0, 599) == 0);
            step();
            rst = 1'b0;
            if (tk) tod = (tod + 1) % 86400;
        end

        @(negedge clk);
        @(negedge clk);
        chk("sb_drain", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
